// File: rtl/key_dispatcher.sv
// key_dispatcher: hands candidate keys KEY_MIN..KEY_MAX to a bank of single-key
// arcfour cores, gathers their pass/fail pulses, latches the first winning key and
// aborts the rest of the bank once a winner is seen.
module key_dispatcher #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned KEY_BITS = 24,
  parameter logic [KEY_BITS-1:0] KEY_MIN = '0,
  parameter logic [KEY_BITS-1:0] KEY_MAX = KEY_BITS'(24'h3FFFFF),
  parameter int unsigned ABORT_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [NUM_CORES-1:0]          core_start,
  output logic [NUM_CORES*KEY_BITS-1:0] core_key,
  output logic                          core_key_select,
  input  logic [NUM_CORES-1:0]          core_succeeded,
  input  logic [NUM_CORES-1:0]          core_failed,
  output logic                          core_abort,
  output logic                          busy,
  output logic                          found,
  output logic                          exhausted,
  output logic [KEY_BITS-1:0]           found_key,
  output logic [KEY_BITS:0]             keys_tried
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CntW = KEY_BITS + 1;
  localparam int unsigned AbW  = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRun, StAbort, StFound, StExhausted} state_e;

  state_e                state_q, state_d;
  logic [KEY_BITS-1:0]   next_key_q, next_key_d;
  logic                  issued_all_q, issued_all_d;
  logic [NUM_CORES-1:0]  core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0]  core_start_q, core_start_d;
  logic [KEY_BITS-1:0]   core_key_q [NUM_CORES];
  logic [KEY_BITS-1:0]   core_key_d [NUM_CORES];
  logic [KEY_BITS-1:0]   found_key_q, found_key_d;
  logic [CntW-1:0]       keys_tried_q, keys_tried_d;
  logic [AbW-1:0]        abort_cnt_q, abort_cnt_d;

  // Results from cores we did not hand a key to are stale and must not count.
  logic [NUM_CORES-1:0]  live_succ, live_fail, free_cores;
  logic [IdxW-1:0]       win_idx, issue_idx;
  logic                  win_valid, issue_valid;

  function automatic logic [CntW-1:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [CntW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      n = n + CntW'(v[i]);
    end
    return n;
  endfunction

  // Qualify results by busy; a core is free once idle and its last start pulse has dropped.
  always_comb begin
    live_succ  = core_succeeded & core_busy_q;
    live_fail  = core_failed & core_busy_q;
    free_cores = ~core_busy_q & ~core_start_q;
  end

  // Lowest-index priority pick for both the winner and the next core to load.
  always_comb begin
    win_valid   = 1'b0;
    win_idx     = '0;
    issue_valid = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!win_valid && live_succ[i]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(i);
      end
      if (!issue_valid && free_cores[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IdxW'(i);
      end
    end
  end

  // Next-state: search control, key issue, result accounting and abort timing.
  always_comb begin
    state_d      = state_q;
    next_key_d   = next_key_q;
    issued_all_d = issued_all_q;
    core_busy_d  = core_busy_q;
    core_start_d = '0;
    core_key_d   = core_key_q;
    found_key_d  = found_key_q;
    keys_tried_d = keys_tried_q;
    abort_cnt_d  = abort_cnt_q;
    unique case (state_q)
      StIdle, StFound, StExhausted: begin
        if (start) begin
          state_d      = StRun;
          next_key_d   = KEY_MIN;
          issued_all_d = 1'b0;
          keys_tried_d = '0;
          found_key_d  = '0;
          core_busy_d  = '0;
        end
      end
      StRun: begin
        if (win_valid) begin
          // A success outranks same-cycle failures and any issue.
          found_key_d  = core_key_q[win_idx];
          keys_tried_d = keys_tried_q + popcount(live_succ | live_fail);
          core_busy_d  = '0;
          abort_cnt_d  = AbW'(ABORT_CYCLES - 1);
          state_d      = StAbort;
        end else begin
          keys_tried_d = keys_tried_q + popcount(live_fail);
          core_busy_d  = core_busy_q & ~live_fail;
          if (issued_all_q && (core_busy_q == '0)) begin
            state_d = StExhausted;
          end else if (!issued_all_q && issue_valid) begin
            // A core that just failed is still busy this cycle, so its next start
            // pulse lands two cycles after the failure at the earliest.
            core_start_d[issue_idx] = 1'b1;
            core_busy_d[issue_idx]  = 1'b1;
            core_key_d[issue_idx]   = next_key_q;
            if (next_key_q == KEY_MAX) begin
              issued_all_d = 1'b1;
            end else begin
              next_key_d = next_key_q + 1'b1;
            end
          end
        end
      end
      StAbort: begin
        core_busy_d = '0;
        if (abort_cnt_q == '0) begin
          state_d = StFound;
        end else begin
          abort_cnt_d = abort_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      next_key_q   <= KEY_MIN;
      issued_all_q <= 1'b0;
      core_busy_q  <= '0;
      core_start_q <= '0;
      found_key_q  <= '0;
      keys_tried_q <= '0;
      abort_cnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        core_key_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      next_key_q   <= next_key_d;
      issued_all_q <= issued_all_d;
      core_busy_q  <= core_busy_d;
      core_start_q <= core_start_d;
      found_key_q  <= found_key_d;
      keys_tried_q <= keys_tried_d;
      abort_cnt_q  <= abort_cnt_d;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        core_key_q[i] <= core_key_d[i];
      end
    end
  end

  // Outputs decode straight from registered state.
  always_comb begin
    core_start      = core_start_q;
    core_key_select = 1'b1;
    core_key        = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      core_key[i*KEY_BITS +: KEY_BITS] = core_key_q[i];
    end
    core_abort = (state_q == StAbort);
    busy       = (state_q == StRun) || (state_q == StAbort);
    found      = (state_q == StFound);
    exhausted  = (state_q == StExhausted);
    found_key  = found_key_q;
    keys_tried = keys_tried_q;
  end

endmodule

// File: tb/tb_key_dispatcher.sv
// Bench for key_dispatcher: three 2-core instances (range 0..3, range 0..7, single key
// 0x1234) driven by latency-programmable stub cores. Expected issues, abort lengths and
// final results are queued at stimulus time and checked by a separate monitor.
module tb_key_dispatcher;
  localparam int NC = 2;
  localparam int KB = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic           start [3];
  logic [NC-1:0]  cs [3];
  logic [NC*KB-1:0] ck [3];
  logic           ksel [3];
  logic [NC-1:0]  succ [3];
  logic [NC-1:0]  fail [3];
  logic           abort [3];
  logic           bsy [3];
  logic           fnd [3];
  logic           exh [3];
  logic [KB-1:0]  fk [3];
  logic [KB:0]    kt [3];

  key_dispatcher #(.NUM_CORES(2), .KEY_BITS(24), .KEY_MIN(24'h0), .KEY_MAX(24'h3),
                   .ABORT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .core_start(cs[0]), .core_key(ck[0]),
    .core_key_select(ksel[0]), .core_succeeded(succ[0]), .core_failed(fail[0]),
    .core_abort(abort[0]), .busy(bsy[0]), .found(fnd[0]), .exhausted(exh[0]),
    .found_key(fk[0]), .keys_tried(kt[0]));

  key_dispatcher #(.NUM_CORES(2), .KEY_BITS(24), .KEY_MIN(24'h0), .KEY_MAX(24'h7),
                   .ABORT_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .core_start(cs[1]), .core_key(ck[1]),
    .core_key_select(ksel[1]), .core_succeeded(succ[1]), .core_failed(fail[1]),
    .core_abort(abort[1]), .busy(bsy[1]), .found(fnd[1]), .exhausted(exh[1]),
    .found_key(fk[1]), .keys_tried(kt[1]));

  key_dispatcher #(.NUM_CORES(2), .KEY_BITS(24), .KEY_MIN(24'h1234), .KEY_MAX(24'h1234),
                   .ABORT_CYCLES(2)) dut_c (
    .clk(clk), .reset(reset), .start(start[2]), .core_start(cs[2]), .core_key(ck[2]),
    .core_key_select(ksel[2]), .core_succeeded(succ[2]), .core_failed(fail[2]),
    .core_abort(abort[2]), .busy(bsy[2]), .found(fnd[2]), .exhausted(exh[2]),
    .found_key(fk[2]), .keys_tried(kt[2]));

  typedef struct { int inst; int core; logic [23:0] key; int dly; } issue_t;
  typedef struct { int inst; logic f; logic e; logic [23:0] fkey; logic [24:0] kt; int dly; } res_t;
  typedef struct { int inst; int len; } abort_t;

  issue_t q_issue [$];
  res_t   q_res [$];
  abort_t q_abort [$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lat [3][2];
  int timer [3][2];
  logic [23:0] skey [3][2];
  logic [7:0] succ_mask [3];
  int last_fail [3][2];
  int start_cyc [3];
  bit [NC-1:0] prev_cs [3];
  bit prev_done [3];
  int abort_len [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_issue(input int i, input int c, input logic [23:0] k, input int d);
    issue_t e;
    e.inst = i; e.core = c; e.key = k; e.dly = d;
    q_issue.push_back(e);
  endtask

  task automatic exp_res(input int i, input logic f, input logic e, input logic [23:0] fkey,
                         input logic [24:0] n, input int d);
    res_t r;
    r.inst = i; r.f = f; r.e = e; r.fkey = fkey; r.kt = n; r.dly = d;
    q_res.push_back(r);
  endtask

  task automatic exp_abort(input int i, input int len);
    abort_t a;
    a.inst = i; a.len = len;
    q_abort.push_back(a);
  endtask

  // Stub cores: answer lat cycles after a start pulse, succeeding on keys in succ_mask.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      succ[i] = '0;
      fail[i] = '0;
      for (int c = 0; c < NC; c++) begin
        if (reset) begin
          timer[i][c] = 0;
        end else if (cs[i][c]) begin
          timer[i][c] = lat[i][c];
          skey[i][c] = ck[i][c*KB +: KB];
        end else if (timer[i][c] > 0) begin
          timer[i][c]--;
          if (timer[i][c] == 0) begin
            if (skey[i][c] < 24'd8 && succ_mask[i][skey[i][c][2:0]]) begin
              succ[i][c] = 1'b1;
            end else begin
              fail[i][c] = 1'b1;
              last_fail[i][c] = cyc;
            end
          end
        end
      end
    end
  end

  // Monitor: compare each start pulse, abort burst and final result against the queues.
  always @(negedge clk) begin
    issue_t e;
    res_t r;
    abort_t a;
    bit done;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NC; c++) begin
        if (cs[i][c] === 1'b1) begin
          if (q_issue.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: inst %0d core %0d key 0x%0h, required no start",
                     i, c, ck[i][c*KB +: KB]);
          end else begin
            e = q_issue.pop_front();
            chk("start_inst", i, e.inst);
            chk("start_core", c, e.core);
            chk("start_key", ck[i][c*KB +: KB], e.key);
            chk("start_cycle", cyc - start_cyc[i], e.dly);
          end
          chk("start_spacing", prev_cs[i][c], 0);
          chk("reissue_gap", (last_fail[i][c] == 0) || (cyc - last_fail[i][c] >= 2), 1);
        end
      end
      prev_cs[i] = cs[i];
      if (abort[i] === 1'b1) begin
        abort_len[i]++;
      end else if (abort_len[i] > 0) begin
        if (q_abort.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_abort: inst %0d length %0d, required none", i, abort_len[i]);
        end else begin
          a = q_abort.pop_front();
          chk("abort_inst", i, a.inst);
          chk("abort_len", abort_len[i], a.len);
        end
        abort_len[i] = 0;
      end
      done = (fnd[i] === 1'b1) || (exh[i] === 1'b1);
      if (done && !prev_done[i]) begin
        if (q_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: inst %0d found %0b exhausted %0b, required none",
                   i, fnd[i], exh[i]);
        end else begin
          r = q_res.pop_front();
          chk("res_inst", i, r.inst);
          chk("res_found", fnd[i], r.f);
          chk("res_exhausted", exh[i], r.e);
          chk("res_found_key", fk[i], r.fkey);
          chk("res_keys_tried", kt[i], r.kt);
          chk("res_cycle", cyc - start_cyc[i], r.dly);
        end
      end
      prev_done[i] = done;
    end
  end

  task automatic pulse_start(input int i, input bit record);
    @(negedge clk);
    start[i] = 1'b1;
    if (record) start_cyc[i] = cyc;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int k;
    k = 0;
    while (!(fnd[i] === 1'b1 || exh[i] === 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("done_within_budget", (fnd[i] === 1'b1) || (exh[i] === 1'b1), 1);
    repeat (3) @(negedge clk);
    chk("issue_queue_drained", q_issue.size(), 0);
    chk("result_queue_drained", q_res.size(), 0);
    chk("abort_queue_drained", q_abort.size(), 0);
  endtask

  task automatic chk_reset_values(input int i);
    chk("rst_core_start", cs[i], 0);
    chk("rst_core_key", ck[i], 0);
    chk("rst_key_select", ksel[i], 1);
    chk("rst_core_abort", abort[i], 0);
    chk("rst_busy", bsy[i], 0);
    chk("rst_found", fnd[i], 0);
    chk("rst_exhausted", exh[i], 0);
    chk("rst_found_key", fk[i], 0);
    chk("rst_keys_tried", kt[i], 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      succ_mask[i] = 8'h00;
      start_cyc[i] = 0;
      lat[i][0] = 10;
      lat[i][1] = 10;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_values(i);
    reset = 1'b0;
    @(negedge clk);

    // A1: range 0..3, both cores fail after 10 cycles; a start during RUN is ignored.
    exp_issue(0, 0, 24'h0, 2);
    exp_issue(0, 1, 24'h1, 3);
    exp_issue(0, 0, 24'h2, 14);
    exp_issue(0, 1, 24'h3, 15);
    exp_res(0, 1'b0, 1'b1, 24'h0, 25'd4, 27);
    pulse_start(0, 1'b1);
    repeat (3) @(negedge clk);
    pulse_start(0, 1'b0);
    wait_done(0);

    // A2: restart from EXHAUSTED, key 2 wins; key 3 fails during ABORT and is not counted.
    succ_mask[0] = 8'b0000_0100;
    exp_issue(0, 0, 24'h0, 2);
    exp_issue(0, 1, 24'h1, 3);
    exp_issue(0, 0, 24'h2, 14);
    exp_issue(0, 1, 24'h3, 15);
    exp_abort(0, 2);
    exp_res(0, 1'b1, 1'b0, 24'h2, 25'd3, 27);
    pulse_start(0, 1'b1);
    repeat (23) @(negedge clk);
    pulse_start(0, 1'b0);
    wait_done(0);

    // A3: restart from FOUND; core 1 frees first, so key 2 goes to core 1 in the cycle
    // core 0 fails, and core 0 restarts exactly two cycles after its failure.
    succ_mask[0] = 8'h00;
    lat[0][0] = 3;
    lat[0][1] = 1;
    exp_issue(0, 0, 24'h0, 2);
    exp_issue(0, 1, 24'h1, 3);
    exp_issue(0, 1, 24'h2, 6);
    exp_issue(0, 0, 24'h3, 7);
    exp_res(0, 1'b0, 1'b1, 24'h0, 25'd4, 12);
    pulse_start(0, 1'b1);
    chk("restart_keys_tried", kt[0], 0);
    chk("restart_found", fnd[0], 0);
    chk("restart_found_key", fk[0], 0);
    chk("restart_busy", bsy[0], 1);
    wait_done(0);

    // A4: reset mid-search returns every output to its reset value one cycle later.
    lat[0][0] = 10;
    lat[0][1] = 10;
    exp_issue(0, 0, 24'h0, 2);
    exp_issue(0, 1, 24'h1, 3);
    exp_issue(0, 0, 24'h2, 14);
    pulse_start(0, 1'b1);
    repeat (13) @(negedge clk);
    chk("pre_reset_keys_tried", kt[0], 2);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_values(0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_issue_queue_drained", q_issue.size(), 0);

    // B: range 0..7, skewed latencies make results coincide; keys 4 and 5 both succeed.
    lat[1][0] = 10;
    lat[1][1] = 9;
    succ_mask[1] = 8'b0011_0000;
    exp_issue(1, 0, 24'h0, 2);
    exp_issue(1, 1, 24'h1, 3);
    exp_issue(1, 0, 24'h2, 14);
    exp_issue(1, 1, 24'h3, 15);
    exp_issue(1, 0, 24'h4, 26);
    exp_issue(1, 1, 24'h5, 27);
    exp_abort(1, 2);
    exp_res(1, 1'b1, 1'b0, 24'h4, 25'd6, 39);
    pulse_start(1, 1'b1);
    wait_done(1);

    // C: single key 0x1234 goes to core 0 only; its failure exhausts the range.
    lat[2][0] = 5;
    lat[2][1] = 5;
    exp_issue(2, 0, 24'h1234, 2);
    exp_res(2, 1'b0, 1'b1, 24'h0, 25'd1, 9);
    pulse_start(2, 1'b1);
    wait_done(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_dispatcher.md
Name: key_dispatcher

Overview:
- Upstream scheduler for a bank of NUM_CORES arcfour cracking cores, each run in single-key (switch-key) mode.
- Walks the key range KEY_MIN..KEY_MAX and issues one candidate key per idle core.
- Collects each core's succeeded/failed pulse, latches the first winning key and aborts the remaining cores.
- Reports found/exhausted to the board-level display/LED logic.

Parameters:
- NUM_CORES, 4, number of arcfour cores driven; 1..8.
- KEY_BITS, 24, candidate key width (3 bytes × 8).
- KEY_MIN, 0, first key issued.
- KEY_MAX, 24'h3FFFFF, last key issued (inclusive); KEY_MAX >= KEY_MIN.
- ABORT_CYCLES, 2, length of the core_abort assertion after a success.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle start request.
- core_start  out  NUM_CORES  per-core start pulse.
- core_key  out  NUM_CORES×KEY_BITS  per-core candidate key; held stable while the core is busy.
- core_key_select  out  1  constant 1; selects single-key mode in the cores.
- core_succeeded  in  NUM_CORES  per-core one-cycle success pulse.
- core_failed  in  NUM_CORES  per-core one-cycle failure pulse.
- core_abort  out  1  ORed into every core's reset.
- busy  out  1  search in progress.
- found  out  1  a key was found; sticky.
- exhausted  out  1  every key failed; sticky.
- found_key  out  KEY_BITS  winning key.
- keys_tried  out  KEY_BITS+1  count of completed (failed or succeeded) keys.

Behaviour:
- Reset values: all outputs 0 except core_key_select = 1; state = IDLE; next_key = KEY_MIN; all core_busy bits 0.
- States: IDLE, RUN, ABORT, FOUND, EXHAUSTED.
- IDLE → RUN on start. Clears keys_tried, found_key, found and exhausted; sets next_key = KEY_MIN.
- start is ignored in RUN and ABORT. In FOUND and EXHAUSTED, start behaves as it does in IDLE (restart).
- RUN, issue rule:
  - Each cycle, select the lowest-index core with core_busy = 0 and a gated-off start (see the spacing rule below), provided issued_all = 0.
  - For that core: core_key[c] <= next_key, core_start[c] = 1 for exactly one cycle (registered), core_busy[c] <= 1, next_key <= next_key + 1.
  - When the issued key equals KEY_MAX, set issued_all <= 1 instead of incrementing.
  - At most one issue per cycle.
- Spacing rule: core_start[c] must be low for at least 1 cycle between pulses, because the cores edge-detect start.
- RUN, completion:
  - A core_failed[c] pulse clears core_busy[c] and increments keys_tried.
  - Several failures in the same cycle add popcount(core_failed) to keys_tried.
  - A core may be reissued no earlier than 2 cycles after its failed pulse, so the core has time to return to IDLE.
- RUN, success:
  - Any core_succeeded bit set: the lowest-index succeeding core wins. found_key <= core_key[winner].
  - keys_tried increments by popcount(succeeded | failed).
  - No issue in that cycle. Go to ABORT.
- Success beats failure and beats issue in the same cycle.
- RUN → EXHAUSTED when issued_all = 1, all core_busy bits are 0, and there is no success that cycle.
- ABORT:
  - core_abort = 1 for ABORT_CYCLES cycles; all core_busy cleared; core_start held 0.
  - Results arriving during ABORT are ignored.
  - Then → FOUND.
- FOUND: found = 1, busy = 0. EXHAUSTED: exhausted = 1, busy = 0.
- busy = 1 in RUN and ABORT.
- A result pulse on a core whose core_busy = 0 is ignored and not counted.
- KEY_MIN == KEY_MAX: exactly one key is issued, to core 0.
- Reset mid-search returns to IDLE immediately. core_abort is not asserted; the cores take system reset directly.

Test Plan:
- NUM_CORES=2, KEY_MIN=0, KEY_MAX=3; stub cores fail 10 cycles after start → keys 0,1,2,3 issued to cores 0,1,0,1 → exhausted=1, keys_tried=4, found=0.
- Same setup, stub succeeds on key 2 → found_key=2, core_abort high for 2 cycles, found=1; key 3 never issued or never counted.
- Core 0 succeeds on key 4 and core 1 succeeds on key 5 in the same cycle → found_key=4; keys_tried increments by 2 in that cycle.
- Core 0 fails on key 0 while core 1 is idle → the next key goes to core 1 in the same cycle; core 0 gets no core_start until 2 cycles after its failed pulse.
- start pulsed during RUN → no effect. Reset asserted mid-RUN → next cycle all outputs at reset values. start pulsed in FOUND → search restarts at KEY_MIN and keys_tried is cleared.
- KEY_MIN=KEY_MAX=0x1234 → a single core_start[0] with core_key[0]=0x1234; a fail pulse gives exhausted=1, keys_tried=1.
